// File: rtl/dmem_lane_ctrl.sv
// rtl/dmem_lane_ctrl.sv - byte-lane data-memory controller over four 8-bit banks
// Each lane gets its own row so any misaligned access completes in one bank cycle.
module dmem_lane_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [ADDR_W-1:0]         req_addr_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [4*(ADDR_W-2)-1:0]   bank_addr_o,
  output logic [3:0]                bank_wren_o,
  output logic [31:0]               bank_wdata_o,
  input  logic [31:0]               bank_rdata_i
);

  localparam int ROW_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q, uns_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;

  logic [1:0]          off;
  logic [ROW_W-1:0]    row, row_inc;
  logic [2:0]          nbytes;
  logic [1:0]          lane_sel [4];
  logic [63:0]         rot;
  logic [31:0]         raw, load_val;
  logic                fill;

  assign off     = addr_q[1:0];
  assign row     = addr_q[ADDR_W-1:2];
  assign row_inc = row + ROW_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = ACC;
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write enables come straight from state so an async reset kills them at once.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    bank_wren_o = '0;
    for (int k = 0; k < 4; k++)
      bank_wren_o[k] = (state_q == ACC) && we_q && ({1'b0, lane_sel[k]} < nbytes);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
    end else if (state_q == IDLE && req_valid_i) begin
      addr_q  <= req_addr_i;
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      size_q  <= req_size_i;
      wdata_q <= req_wdata_i;
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  // lane_sel[k] is the access byte index that lands on lane k.
  always_comb begin
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      lane_sel[k] = 2'(k) - off;
      bank_addr_o[ROW_W*k +: ROW_W] = (2'(k) >= off) ? row : row_inc;
      bank_wdata_o[8*k +: 8] = wdata_q[8*lane_sel[k] +: 8];
    end
  end

  assign rot = {bank_rdata_i, bank_rdata_i} >> {off, 3'b000};
  assign raw = rot[31:0];

  always_comb begin
    fill     = 1'b0;
    load_val = '0;
    case (size_q)
      2'b00: begin
        fill     = !uns_q && raw[7];
        load_val = {{24{fill}}, raw[7:0]};
      end
      2'b01: begin
        fill     = !uns_q && raw[15];
        load_val = {{16{fill}}, raw[15:0]};
      end
      2'b10:   load_val = raw;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (state_q == ACC) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= (size_q == 2'b11);
      rsp_rdata_o <= we_q ? 32'h0 : load_val;
    end else begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// tb/tb_dmem_lane_ctrl.sv - directed and random bench for dmem_lane_ctrl
// Banks are modelled as arrays; expected data comes from a flat byte-addressed memory.
module tb_dmem_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [55:0] bank_addr;
  logic [3:0]  bank_wren;
  logic [31:0] bank_wdata, bank_rdata;

  always #5 clk = ~clk;

  dmem_lane_ctrl #(.ADDR_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .bank_addr_o(bank_addr), .bank_wren_o(bank_wren),
    .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
  );

  int          ncomp = 0;
  int          nfail = 0;
  logic [7:0]  ref_mem [65536];
  logic [7:0]  bmem [4][16384];
  logic [31:0] last_rdata;
  logic [7:0]  seed;
  logic        init_busy;
  logic [13:0] init_row;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ seed;
  endfunction

  always_comb
    for (int k = 0; k < 4; k++)
      bank_rdata[8*k +: 8] = bmem[k][bank_addr[14*k +: 14]];

  always @(posedge clk) begin
    if (init_busy) begin
      for (int k = 0; k < 4; k++) bmem[k][init_row] <= pat(4 * int'(init_row) + k);
    end else begin
      for (int k = 0; k < 4; k++)
        if (bank_wren[k]) bmem[k][bank_addr[14*k +: 14]] <= bank_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [15:0] a, input logic [31:0] wd, input bit hold);
    int          n;
    logic [3:0]  used;
    logic [31:0] erd;
    logic [55:0] erows;
    logic [15:0] b;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    used = '0;
    erd  = '0;
    for (int j = 0; j < n; j++) begin
      b = a + 16'(j);
      used[b[1:0]] = 1'b1;
      if (!we) erd = erd | (32'(ref_mem[b]) << (8 * j));
    end
    if (!we && n > 0 && n < 4 && !uns && erd[8*n-1]) erd = erd | ~((32'h1 << (8 * n)) - 32'h1);
    for (int k = 0; k < 4; k++)
      erows[14*k +: 14] = (k >= int'(a[1:0])) ? a[15:2] : a[15:2] + 14'd1;

    @(negedge clk);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    chk("acc_ready", 64'(req_ready), 64'd0);
    chk("acc_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("acc_wren", 64'(bank_wren), 64'(we ? used : 4'b0000));
    chk("acc_rows", 64'(bank_addr), 64'(erows));
    if (we)
      for (int j = 0; j < n; j++) begin
        b = a + 16'(j);
        chk("acc_wdata", 64'(bank_wdata[8*b[1:0] +: 8]), 64'(wd[8*j +: 8]));
      end
    @(posedge clk); #1;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_err", 64'(rsp_err), 64'(n == 0));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(erd));
    last_rdata = rsp_rdata;
    if (we)
      for (int j = 0; j < n; j++) ref_mem[a + 16'(j)] = wd[8*j +: 8];
    @(posedge clk); #1;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("ready_back", 64'(req_ready), 64'd1);
    if (hold) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_no_rsp", 64'(rsp_valid), 64'd0);
      chk("hold_ready", 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_uns = 1'b0; req_addr = '0; req_wdata = '0; last_rdata = '0;
    seed = 8'($urandom);
    init_busy = 1'b1; init_row = '0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = pat(a);
    for (int r = 0; r < 16384; r++) begin
      @(negedge clk);
      init_row = 14'(r);
    end
    @(negedge clk);
    init_busy = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_wren", 64'(bank_wren), 64'd0);
    chk("rst_bank_addr", 64'(bank_addr), 64'd0);
    chk("rst_wdata", 64'(bank_wdata), 64'd0);

    xact(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0);
    xact(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0);
    chk("lw_aligned", 64'(last_rdata), 64'hDEADBEEF);
    xact(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, 1'b0);
    chk("lb_signed", 64'(last_rdata), 64'hFFFFFFDE);
    xact(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, 1'b0);
    chk("lbu", 64'(last_rdata), 64'h000000DE);
    xact(1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, 1'b0);
    chk("lh_signed", 64'(last_rdata), 64'hFFFFBEEF);

    xact(1'b1, 2'd2, 1'b0, 16'h0006, 32'h11223344, 1'b0);
    xact(1'b0, 2'd2, 1'b0, 16'h0006, 32'h0, 1'b0);
    chk("lw_misaligned", 64'(last_rdata), 64'h11223344);
    xact(1'b0, 2'd0, 1'b1, 16'h0008, 32'h0, 1'b0);
    chk("lbu_cross", 64'(last_rdata), 64'h00000022);

    xact(1'b1, 2'd1, 1'b0, 16'hFFFF, 32'h0000A55A, 1'b0);
    chk("wrap_lane3", 64'(bmem[3][16383]), 64'h5A);
    chk("wrap_lane0", 64'(bmem[0][0]), 64'hA5);
    xact(1'b0, 2'd1, 1'b1, 16'hFFFF, 32'h0, 1'b0);
    chk("lhu_wrap", 64'(last_rdata), 64'h0000A55A);

    xact(1'b1, 2'd3, 1'b0, 16'h0020, 32'hFFFFFFFF, 1'b0);
    chk("illegal_rdata", 64'(last_rdata), 64'h0);
    xact(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 1'b0);

    xact(1'b0, 2'd2, 1'b1, 16'h0010, 32'h0, 1'b1);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 16'h0040; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_wren_before", 64'(bank_wren), 64'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wren_async", 64'(bank_wren), 64'h0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("rst_mid_ready_after", 64'(req_ready), 64'd1);
    chk("rst_mid_mem", 64'(bmem[0][16]), 64'(ref_mem[16'h0040]));
    xact(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [15:0] a;
      bit          hold;
      int          sel;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sel  = $urandom_range(0, 3);
      if (sel == 0)      a = 16'hFFFC + 16'($urandom_range(0, 3));
      else if (sel == 1) a = 16'($urandom_range(0, 3));
      else               a = 16'($urandom_range(0, 127));
      hold = ($urandom_range(0, 7) == 0);
      xact(we, sz, uns, a, $urandom, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
